// File: rtl/sec_shadow_stack_if.sv
// Instruction stream, status and clear bundle between the jump filter and the shadow stack.
// master drives instructions/out_ready/clear; slave is the shadow-stack stage.
interface sec_shadow_stack_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [63:0]             in_instr;
  logic [AW-1:0]           in_pc;
  logic [AW-1:0]           in_target;
  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             out_instr;
  logic                    violation;
  logic [1:0]              viol_code;
  logic [AW-1:0]           viol_pc;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  depth;
  logic                    clr_violation;

  modport master (
    output in_valid, in_instr, in_pc, in_target, out_ready, clr_violation,
    input  in_ready, out_valid, out_instr, violation, viol_code, viol_pc, overflow, depth
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_target, out_ready, clr_violation,
    output in_ready, out_valid, out_instr, violation, viol_code, viol_pc, overflow, depth
  );
endinterface

// File: rtl/sec_shadow_stack.sv
// Return-address shadow stack: pushes on calls, checks returns, NOPs and stalls on violation.
// 1-cycle accept-to-output latency; in_ready follows the output register, forced low in ALERT.
module sec_shadow_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  sec_shadow_stack_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL    = DW'(DEPTH);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [AW-1:0] RET_OFS = AW'(8);

  typedef enum logic {ST_RUN, ST_ALERT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   top_q, top_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_instr_q, out_instr_d;
  logic            violation_q, violation_d;
  logic [1:0]      viol_code_q, viol_code_d;
  logic [AW-1:0]   viol_pc_q, viol_pc_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   stack_q [DEPTH];

  logic [5:0]      op, funct;
  logic [4:0]      rs;
  logic            is_call, is_ret;
  logic            in_rdy, accept, push_en;
  logic [1:0]      ret_code;
  logic [AW-1:0]   top_entry;

  assign op      = bus.in_instr[31:26];
  assign funct   = bus.in_instr[5:0];
  assign rs      = bus.in_instr[25:21];
  assign is_call = (op == 6'd3) || ((op == 6'd0) && (funct == 6'd9));
  assign is_ret  = (op == 6'd0) && (funct == 6'd8) && (rs == 5'd31);

  // top_q points at the next free slot; the most recent push sits one below it.
  assign top_entry = stack_q[top_q - P_ONE];

  always_comb begin
    state_d     = state_q;
    top_d       = top_q;
    depth_d     = depth_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    violation_d = violation_q;
    viol_code_d = viol_code_q;
    viol_pc_d   = viol_pc_q;
    overflow_d  = overflow_q;
    push_en     = 1'b0;
    ret_code    = 2'd0;
    in_rdy      = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    accept      = bus.in_valid && in_rdy;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = bus.in_instr;
          if (is_call) begin
            // When full, the write slot is the oldest entry, so the ring simply overwrites it.
            push_en = 1'b1;
            top_d   = top_q + P_ONE;
            if (depth_q != FULL) begin
              depth_d = depth_q + D_ONE;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (is_ret) begin
            if (depth_q == '0) begin
              ret_code = 2'd2;
            end else begin
              top_d   = top_q - P_ONE;
              depth_d = depth_q - D_ONE;
              if (top_entry != bus.in_target) begin
                ret_code = 2'd1;
              end
            end
            if (ret_code != 2'd0) begin
              violation_d = 1'b1;
              viol_code_d = ret_code;
              viol_pc_d   = bus.in_pc;
              out_instr_d = '0;
              state_d     = ST_ALERT;
            end
          end
        end
      end
      ST_ALERT: begin
        if (bus.clr_violation) begin
          state_d     = ST_RUN;
          depth_d     = '0;
          violation_d = 1'b0;
          viol_code_d = 2'd0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      top_q       <= '0;
      depth_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      violation_q <= 1'b0;
      viol_code_q <= 2'd0;
      viol_pc_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      depth_q     <= depth_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      violation_q <= violation_d;
      viol_code_q <= viol_code_d;
      viol_pc_q   <= viol_pc_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry contents need no reset: depth gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) begin
      stack_q[top_q] <= bus.in_pc + RET_OFS;
    end
  end

  assign bus.in_ready  = rst_n && in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.violation = violation_q;
  assign bus.viol_code = viol_code_q;
  assign bus.viol_pc   = viol_pc_q;
  assign bus.overflow  = overflow_q;
  assign bus.depth     = depth_q;
endmodule

// File: doc/sec_shadow_stack.md
# sec_shadow_stack

Return-address shadow stack that consumes the filtered 64-bit instruction stream from the jump-security filter stage, one committed instruction per handshake. It pushes the return address on every call (JAL, JALR), and on every return (JR $31) pops and compares against the actual jump target. A mismatch or an empty-stack pop raises a sticky violation, replaces the offending instruction with a NOP, and stalls the stream until software clears it.

## Interface
- DEPTH, 16: shadow stack entries; power of two, at least 2.
- AW, 32: address width of PC and target.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  64  filtered instruction; bits [31:0] are the MIPS word, bits [63:32] pass through unchanged.
- in_pc  in  AW  PC of in_instr.
- in_target  in  AW  resolved jump target (register value for JR).
- out_valid  out  1  downstream instruction valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  64  registered instruction, or 0 on a violating return.
- violation  out  1  sticky violation flag.
- viol_code  out  2  0 none, 1 mismatch, 2 underflow.
- viol_pc  out  AW  PC of the first violating return.
- overflow  out  1  sticky; set when a push overwrote the oldest entry.
- depth  out  $clog2(DEPTH)+1  current occupancy.
- clr_violation  in  1  one-cycle pulse that clears the violation and flushes the stack.

## Operation
- Decode from in_instr[31:0]:
  - op = [31:26], funct = [5:0], rs = [25:21].
  - CALL: op==3, or op==0 && funct==9.
  - RET: op==0 && funct==8 && rs==31.
  - Every other instruction is OTHER.
- An instruction is accepted when in_valid && in_ready.
- CALL on accept:
  - Push in_pc+8, computed modulo 2^AW.
  - If depth<DEPTH, depth increments.
  - If depth==DEPTH, the write overwrites the oldest entry in a circular buffer, depth stays DEPTH, and overflow is set.
- RET on accept:
  - If depth==0: underflow, viol_code=2.
  - Else pop the top entry and decrement depth.
  - If the popped entry != in_target: mismatch, viol_code=1.
- OTHER: the stack is unchanged.
- On a violation:
  - Set violation, latch viol_pc=in_pc and viol_code.
  - The output word for that instruction is 64'h0.
  - The FSM moves to ALERT.
- FSM states:
  - RUN: in_ready = !out_valid || out_ready.
  - ALERT: in_ready=0. The already-registered output still drains.
  - ALERT to RUN on clr_violation.
  - clr_violation in RUN is ignored.
- Clear action, on the cycle clr_violation is sampled in ALERT:
  - depth, violation and viol_code go to 0.
  - viol_pc and overflow are kept; overflow is cleared only by reset.
- Output register: holds until out_ready. A new accept and a drain may occur in the same cycle, giving full throughput.

## Timing
- Reset values: in_ready=0 during reset, then 1 from the first cycle after rst_n rises. out_valid=0, out_instr=0, violation=0, viol_code=0, viol_pc=0, overflow=0, depth=0, FSM=RUN.
- Latency: 1 cycle from accept to out_valid/out_instr.
- Stack effects: depth and stack contents update the edge after accept.
- Violation timing: violation and viol_code assert in the same cycle as the corresponding out_valid.
- in_ready is 0 from the cycle violation asserts.
- Back-to-back CALL then RET: the RET compares against the value pushed one cycle earlier, with no bubble. This requires a bypass or a stack write visible in the next cycle.
- Reset mid-operation: a reset low at any edge overrides all other actions, including a pending accept or clear.
- clr_violation and rst_n low together: reset wins.

## Test plan
- Call/return match: JAL (32'h0C000040) at pc 0x100, then JR $31 (32'h03E00008) with target 0x108 -> depth 0→1→0, violation=0, both words pass unchanged one cycle after accept.
- Mismatch: JAL at 0x200, then JR $31 with target 0x300 -> violation=1, viol_code=1, viol_pc = JR's pc, out_instr=0, in_ready=0. Pulse clr_violation -> depth=0, in_ready=1 next cycle.
- Underflow: JR $31 from reset with target 0x40 -> viol_code=2, out_instr=0.
- Overflow wrap: 17 JALs at pcs 0x0,0x10,…,0x100 with DEPTH=16 -> overflow=1, depth=16. Then 16 RETs with targets 0x108 down to 0x18 all match, and a 17th RET underflows.
- Backpressure: hold out_ready=0 with a CALL pending -> out_instr stable, in_ready=0, no second push. Release -> stream resumes with no loss or duplication.
- Reset mid-stream: depth=3 and violation=1, then rst_n=0 for one cycle -> all outputs return to their reset values on the next edge.
